// File: rtl/phys_reg_free_list_if.sv
// Rename/retire-side bundle of the physical register free list: 4-wide allocate and 4-lane release.
interface phys_reg_free_list_if #(
    parameter int unsigned TAG_WIDTH = 6,
    parameter int unsigned FL_INDEX  = 5
);
    logic                 alloc_req_i;
    logic [TAG_WIDTH-1:0] alloc_tag0_o;
    logic [TAG_WIDTH-1:0] alloc_tag1_o;
    logic [TAG_WIDTH-1:0] alloc_tag2_o;
    logic [TAG_WIDTH-1:0] alloc_tag3_o;
    logic                 alloc_stall_o;
    logic [3:0]           free_valid_i;
    logic [TAG_WIDTH-1:0] free_tag0_i;
    logic [TAG_WIDTH-1:0] free_tag1_i;
    logic [TAG_WIDTH-1:0] free_tag2_i;
    logic [TAG_WIDTH-1:0] free_tag3_i;
    logic [FL_INDEX:0]    free_count_o;
    logic                 overflow_o;

    modport master (
        output alloc_req_i, free_valid_i,
        output free_tag0_i, free_tag1_i, free_tag2_i, free_tag3_i,
        input  alloc_tag0_o, alloc_tag1_o, alloc_tag2_o, alloc_tag3_o,
        input  alloc_stall_o, free_count_o, overflow_o
    );

    modport slave (
        input  alloc_req_i, free_valid_i,
        input  free_tag0_i, free_tag1_i, free_tag2_i, free_tag3_i,
        output alloc_tag0_o, alloc_tag1_o, alloc_tag2_o, alloc_tag3_o,
        output alloc_stall_o, free_count_o, overflow_o
    );
endinterface

// File: rtl/phys_reg_free_list.sv
// Circular free list of physical register tags: pops 4 tags per cycle for rename,
// accepts up to 4 compacted releases per cycle from retire.
module phys_reg_free_list #(
    parameter int unsigned FL_DEPTH  = 32,
    parameter int unsigned FL_INDEX  = 5,
    parameter int unsigned TAG_WIDTH = 6,
    parameter int unsigned TAG_BASE  = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    phys_reg_free_list_if.slave        fl
);
    localparam int unsigned LANES = 4;
    localparam int unsigned SW    = FL_INDEX + 2;

    logic [TAG_WIDTH-1:0] entry_q [FL_DEPTH];
    logic [FL_INDEX-1:0]  head_q;
    logic [FL_INDEX-1:0]  tail_q;
    logic [FL_INDEX:0]    count_q;
    logic                 overflow_q;

    logic [TAG_WIDTH-1:0] free_tag_c [LANES];
    logic [FL_INDEX-1:0]  wr_idx_c   [LANES];
    logic [LANES-1:0]     accept_c;
    logic [2:0]           valid_cnt_c;
    logic [2:0]           acc_cnt_c;
    logic [SW-1:0]        space_c;
    logic                 stall_c;
    logic                 pop_c;
    logic [FL_INDEX-1:0]  head_next_c;
    logic [FL_INDEX-1:0]  tail_next_c;
    logic [FL_INDEX:0]    count_next_c;
    logic                 overflow_next_c;

    // Asynchronous read of the 4-entry head window
    assign fl.alloc_tag0_o  = entry_q[head_q];
    assign fl.alloc_tag1_o  = entry_q[head_q + FL_INDEX'(1)];
    assign fl.alloc_tag2_o  = entry_q[head_q + FL_INDEX'(2)];
    assign fl.alloc_tag3_o  = entry_q[head_q + FL_INDEX'(3)];
    assign fl.alloc_stall_o = stall_c;
    assign fl.free_count_o  = count_q;
    assign fl.overflow_o    = overflow_q;

    assign stall_c = (count_q < (FL_INDEX+1)'(LANES));
    assign pop_c   = fl.alloc_req_i && !stall_c;

    always_comb begin
        free_tag_c[0] = fl.free_tag0_i;
        free_tag_c[1] = fl.free_tag1_i;
        free_tag_c[2] = fl.free_tag2_i;
        free_tag_c[3] = fl.free_tag3_i;
    end

    // Lane compaction: a valid lane's slot is its rank among valid lanes; ranks beyond free space drop
    always_comb begin
        space_c     = SW'(FL_DEPTH) - SW'(count_q) + (pop_c ? SW'(LANES) : SW'(0));
        valid_cnt_c = '0;
        acc_cnt_c   = '0;
        accept_c    = '0;
        for (int k = 0; k < LANES; k++) begin
            wr_idx_c[k] = tail_q + FL_INDEX'(valid_cnt_c);
            accept_c[k] = fl.free_valid_i[k] && (SW'(valid_cnt_c) < space_c);
            valid_cnt_c = valid_cnt_c + 3'(fl.free_valid_i[k]);
            acc_cnt_c   = acc_cnt_c + 3'(accept_c[k]);
        end
    end

    always_comb begin
        head_next_c     = head_q + (pop_c ? FL_INDEX'(LANES) : FL_INDEX'(0));
        tail_next_c     = tail_q + FL_INDEX'(acc_cnt_c);
        count_next_c    = count_q - (pop_c ? (FL_INDEX+1)'(LANES) : (FL_INDEX+1)'(0))
                        + (FL_INDEX+1)'(acc_cnt_c);
        overflow_next_c = overflow_q || (valid_cnt_c != acc_cnt_c);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < FL_DEPTH; i++) begin
                entry_q[i] <= TAG_WIDTH'(TAG_BASE + unsigned'(i));
            end
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= (FL_INDEX+1)'(FL_DEPTH);
            overflow_q <= 1'b0;
        end else begin
            for (int k = 0; k < LANES; k++) begin
                if (accept_c[k]) begin
                    entry_q[wr_idx_c[k]] <= free_tag_c[k];
                end
            end
            head_q     <= head_next_c;
            tail_q     <= tail_next_c;
            count_q    <= count_next_c;
            overflow_q <= overflow_next_c;
        end
    end
endmodule

// File: tb/tb_phys_reg_free_list.sv
// Directed vector bench for phys_reg_free_list: allocation, release compaction, wrap, overflow, reset.
module tb_phys_reg_free_list;
    localparam int unsigned TW = 6;
    localparam int unsigned FI = 5;

    typedef struct packed {
        logic            req;
        logic [3:0]      valid;
        logic [3:0][5:0] tags;
        logic [3:0][5:0] exp_tags;
        logic            exp_stall;
        logic [5:0]      exp_count;
        logic            exp_ovf;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;
    vec_t vecs[$];

    phys_reg_free_list_if #(.TAG_WIDTH(TW), .FL_INDEX(FI)) fl_if ();

    phys_reg_free_list #(
        .FL_DEPTH(32), .FL_INDEX(FI), .TAG_WIDTH(TW), .TAG_BASE(32)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .fl   (fl_if.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic req, input logic [3:0] valid,
                                input int t0, input int t1, input int t2, input int t3,
                                input int e0, input int e1, input int e2, input int e3,
                                input logic stall, input int count, input logic ovf);
        vec_t v;
        v.req         = req;
        v.valid       = valid;
        v.tags[0]     = 6'(t0);
        v.tags[1]     = 6'(t1);
        v.tags[2]     = 6'(t2);
        v.tags[3]     = 6'(t3);
        v.exp_tags[0] = 6'(e0);
        v.exp_tags[1] = 6'(e1);
        v.exp_tags[2] = 6'(e2);
        v.exp_tags[3] = 6'(e3);
        v.exp_stall   = stall;
        v.exp_count   = 6'(count);
        v.exp_ovf     = ovf;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [3:0][5:0] etags,
                                 input logic estall, input logic [5:0] ecount, input logic eovf);
        logic [23:0] got;
        got = {fl_if.alloc_tag3_o, fl_if.alloc_tag2_o, fl_if.alloc_tag1_o, fl_if.alloc_tag0_o};
        chk({tag, ".tags"},     32'(got),                etags);
        chk({tag, ".stall"},    32'(fl_if.alloc_stall_o), 32'(estall));
        chk({tag, ".count"},    32'(fl_if.free_count_o),  32'(ecount));
        chk({tag, ".overflow"}, 32'(fl_if.overflow_o),    32'(eovf));
    endtask

    task automatic drive(input logic req, input logic [3:0] valid, input logic [3:0][5:0] tags);
        fl_if.alloc_req_i  = req;
        fl_if.free_valid_i = valid;
        fl_if.free_tag0_i  = tags[0];
        fl_if.free_tag1_i  = tags[1];
        fl_if.free_tag2_i  = tags[2];
        fl_if.free_tag3_i  = tags[3];
    endtask

    initial begin
        logic [3:0][5:0] reset_tags;
        logic [3:0][5:0] tv;
        reset_tags = {6'd35, 6'd34, 6'd33, 6'd32};

        // Seven pops, then an eighth that empties the list
        for (int p = 1; p <= 7; p++) begin
            vecs.push_back(mk(1'b1, 4'b0000, 0, 0, 0, 0,
                              32+4*p, 33+4*p, 34+4*p, 35+4*p, 1'b0, 32-4*p, 1'b0));
        end
        vecs.push_back(mk(1'b1, 4'b0000, 0, 0, 0, 0, 32, 33, 34, 35, 1'b1, 0, 1'b0));
        // Empty: request refused, sparse lanes compacted into tail slots
        vecs.push_back(mk(1'b1, 4'b1010, 0, 9, 0, 5, 9, 5, 34, 35, 1'b1, 2, 1'b0));
        vecs.push_back(mk(1'b0, 4'b0011, 10, 11, 0, 0, 9, 5, 10, 11, 1'b0, 4, 1'b0));
        // count==4: pop and release together
        vecs.push_back(mk(1'b1, 4'b1111, 20, 21, 22, 23, 20, 21, 22, 23, 1'b0, 4, 1'b0));
        // Steady 4-in/4-out across pointer wrap
        for (int c = 0; c < 20; c++) begin
            vecs.push_back(mk(1'b1, 4'b1111, c*4, c*4+1, c*4+2, c*4+3,
                              c*4, c*4+1, c*4+2, c*4+3, 1'b0, 4, 1'b0));
        end
        // Refill toward full, then overflow on a partial accept
        for (int a = 0; a < 6; a++) begin
            vecs.push_back(mk(1'b0, 4'b1111, 40+4*a, 41+4*a, 42+4*a, 43+4*a,
                              12, 13, 14, 15, 1'b0, 4+4*(a+1), 1'b0));
        end
        vecs.push_back(mk(1'b0, 4'b0111, 7, 8, 9, 0, 12, 13, 14, 15, 1'b0, 31, 1'b0));
        vecs.push_back(mk(1'b0, 4'b0111, 1, 2, 3, 0, 12, 13, 14, 15, 1'b0, 32, 1'b1));
        vecs.push_back(mk(1'b0, 4'b0000, 0, 0, 0, 0, 12, 13, 14, 15, 1'b0, 32, 1'b1));
        vecs.push_back(mk(1'b1, 4'b0000, 0, 0, 0, 0, 40, 41, 42, 43, 1'b0, 28, 1'b1));

        tv = '0;
        reset = 1'b1;
        drive(1'b0, 4'b0000, tv);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_outputs("reset", reset_tags, 1'b0, 6'd32, 1'b0);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_outputs("idle", reset_tags, 1'b0, 6'd32, 1'b0);

        foreach (vecs[i]) begin
            drive(vecs[i].req, vecs[i].valid, vecs[i].tags);
            @(posedge clk);
            @(negedge clk);
            check_outputs($sformatf("vec%0d", i), vecs[i].exp_tags,
                          vecs[i].exp_stall, vecs[i].exp_count, vecs[i].exp_ovf);
        end

        // Reset dominates a simultaneous pop and release
        tv = {6'd4, 6'd3, 6'd2, 6'd1};
        reset = 1'b1;
        drive(1'b1, 4'b1111, tv);
        @(posedge clk);
        @(negedge clk);
        check_outputs("mid_reset", reset_tags, 1'b0, 6'd32, 1'b0);
        reset = 1'b0;
        tv = '0;
        drive(1'b1, 4'b0000, tv);
        @(posedge clk);
        @(negedge clk);
        check_outputs("post_reset_pop", {6'd39, 6'd38, 6'd37, 6'd36}, 1'b0, 6'd28, 1'b0);
        drive(1'b0, 4'b0000, tv);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
